// File: rtl/vga_img_pkg.sv
// Shared definitions for the VGA image path.
// Holds the row-writer FSM state type, the default word and row widths,
// and the layout of the 8-bit RAM word address {bank, row_idx[5:0], half}.
// packAddr builds that address from its three fields.
package vga_img_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int ROW_W_DEF  = 2 * WORD_W_DEF;
  localparam int ADDR_W     = 8;
  localparam int ADDR_IDX_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_LO = 2'd1,
    ST_WR_HI = 2'd2
  } wrState_t;

  function automatic logic [ADDR_W-1:0] packAddr(
    input logic                  bank,
    input logic [ADDR_IDX_W-1:0] idx,
    input logic                  half
  );
    return {bank, idx, half};
  endfunction

endpackage

// File: rtl/row_ram_writer.sv
// row_ram_writer
// Takes one edge-detected pixel row per transfer from the coprocessor and
// writes it into an external frame RAM as two words, low half first.
// Every output comes straight from a register.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high reset
//   row_data   : ROW_W-bit pixel row
//   row_sof    : row_data is row 0 of a new frame
//   row_valid  : row_data/row_sof valid
//   row_ready  : a row is accepted this cycle when row_valid is also high
//   wr_data    : RAM write data (WORD_W bits)
//   wr_addr    : RAM word address {bank, row_idx, half}
//   wr_en      : RAM write strobe
//   frame_done : one-cycle pulse after the last row of a frame is written
//   disp_bank  : bank the VGA reader should display
//
// Configuration macro FRAME_DOUBLE_BUFFER_EN: when defined, the write bank
// flips after every completed frame and disp_bank points at the other bank.
// When it is not defined, both banks stay at 0.
module row_ram_writer
  import vga_img_pkg::*;
#(
  parameter int ROWS   = 64,
  parameter int ROW_W  = ROW_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROW_W-1:0]  row_data,
  input  logic              row_sof,
  input  logic              row_valid,
  output logic              row_ready,
  output logic [WORD_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              frame_done,
  output logic              disp_bank
);

  localparam int IDX_W = $clog2(ROWS);

  wrState_t          r_state, w_nextState;
  logic [ROW_W-1:0]  r_row, w_row;
  logic [IDX_W-1:0]  r_rowIdx, w_rowIdx;
  logic              r_wbank, w_wbank;
  logic              r_dispBank, w_dispBank;
  logic              r_wrEn, w_wrEn;
  logic [WORD_W-1:0] r_wrData, w_wrData;
  logic [ADDR_W-1:0] r_wrAddr, w_wrAddr;
  logic              r_frameDone, w_frameDone;
  logic              r_rowReady, w_rowReady;

  logic              w_accept;
  logic              w_frameEnd;
  logic [IDX_W-1:0]  w_idxAfter;
  logic [IDX_W-1:0]  w_acceptIdx;

  // Ready is a register rather than a decode of the state so that it is
  // held low through reset and rises on the first clock after it.
  assign w_accept   = row_valid && r_rowReady;

  // Leaving WR_HI finishes the current row; the index (and, at the last
  // row, the frame) advance on that same edge, so a row accepted in
  // WR_HI must already be addressed with the advanced values.
  assign w_frameEnd = (r_state == ST_WR_HI) && (r_rowIdx == IDX_W'(ROWS - 1));
  assign w_idxAfter = (r_state == ST_WR_HI) ? r_rowIdx + IDX_W'(1) : r_rowIdx;

  // A start-of-frame row always lands at row 0, dropping any partial frame.
  assign w_acceptIdx = row_sof ? '0 : w_idxAfter;

  // Next-state and next-register values; everything holds unless changed.
  always_comb begin
    w_nextState = r_state;
    w_row       = r_row;
    w_rowIdx    = r_rowIdx;
    w_wbank     = r_wbank;
    w_dispBank  = r_dispBank;
    w_wrEn      = 1'b0;
    w_wrData    = r_wrData;
    w_wrAddr    = r_wrAddr;
    w_frameDone = 1'b0;

    if (w_frameEnd) begin
      w_frameDone = 1'b1;
`ifdef FRAME_DOUBLE_BUFFER_EN
      w_wbank    = ~r_wbank;
      w_dispBank = r_wbank;
`endif
    end

    case (r_state)
      ST_WR_LO: begin
        w_wrEn      = 1'b1;
        w_wrData    = r_row[ROW_W-1:WORD_W];
        w_wrAddr    = packAddr(r_wbank, ADDR_IDX_W'(r_rowIdx), 1'b1);
        w_nextState = ST_WR_HI;
      end
      default: begin
        if (w_accept) begin
          w_row       = row_data;
          w_rowIdx    = w_acceptIdx;
          w_wrEn      = 1'b1;
          w_wrData    = row_data[WORD_W-1:0];
          w_wrAddr    = packAddr(w_wbank, ADDR_IDX_W'(w_acceptIdx), 1'b0);
          w_nextState = ST_WR_LO;
        end else begin
          w_rowIdx    = w_idxAfter;
          w_nextState = ST_IDLE;
        end
      end
    endcase

    w_rowReady = (w_nextState != ST_WR_LO);
  end

  // State and output registers; reset discards any latched row.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_row       <= '0;
      r_rowIdx    <= '0;
      r_wbank     <= 1'b0;
      r_dispBank  <= 1'b0;
      r_wrEn      <= 1'b0;
      r_wrData    <= '0;
      r_wrAddr    <= '0;
      r_frameDone <= 1'b0;
      r_rowReady  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_row       <= w_row;
      r_rowIdx    <= w_rowIdx;
      r_wbank     <= w_wbank;
      r_dispBank  <= w_dispBank;
      r_wrEn      <= w_wrEn;
      r_wrData    <= w_wrData;
      r_wrAddr    <= w_wrAddr;
      r_frameDone <= w_frameDone;
      r_rowReady  <= w_rowReady;
    end
  end

  assign row_ready  = r_rowReady;
  assign wr_data    = r_wrData;
  assign wr_addr    = r_wrAddr;
  assign wr_en      = r_wrEn;
  assign frame_done = r_frameDone;
  assign disp_bank  = r_dispBank;

endmodule
